pcie_egress_segmenter: RTL and testbench
========================================

# pcie_egress_segmenter

Splits a host-bound DMA request (memory write or memory read of arbitrary dword length) into a sequence of PCIe TLPs. Each TLP respects Max Payload Size (writes), Max Read Request Size (reads) and 4 KB address boundaries. Sits directly upstream of the egress TLP builder: drives its command/address/tag/length inputs, sequences its enable/finished handshake, and presents the outgoing write-data FIFO one segment at a time.

## Interface
- TAG_COUNT, 32: read tags issued, 0..TAG_COUNT-1, wrapping; power of two, ≤256.
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- i_cmd_stb  in  1  one-cycle request strobe; ignored while o_busy
- i_cmd_wr  in  1  1 = MWr32, 0 = MRd32
- i_cmd_address  in  32  byte address; bits [1:0] ignored
- i_cmd_dword_cnt  in  24  total dwords
- i_requester_id  in  16  completer/requester ID for reads
- i_max_payload_size  in  3  PCIe encoding, 0=128 B … 5=4096 B; 6/7 treated as 5
- i_max_read_req_size  in  3  same encoding
- o_busy  out  1  request in progress
- o_cmd_done  out  1  one-cycle pulse, request complete
- o_egress_en  out  1  enable to egress builder
- o_egress_command  out  8  8'h40 (MWr32) or 8'h00 (MRd32)
- o_egress_flags  out  14  constant 0
- o_egress_address  out  32  segment byte address, {dw_addr, 2'b00}
- o_egress_requester_id  out  16  i_requester_id, latched per request
- o_egress_tag  out  8  current read tag
- o_egress_req_dword_cnt  out  10  segment length, 1024 encoded as 0
- i_egress_finished  in  1  egress TLP done
- o_fifo_rdy  out  1  segment data available to egress
- i_fifo_act  in  1  egress has claimed the segment
- o_fifo_size  out  24  segment length, dwords (1..1024)
- o_fifo_data  out  32  = i_src_data, combinational
- i_fifo_stb  in  1  egress data pop
- i_src_count  in  24  dwords currently held in source FIFO
- i_src_data  in  32  source FIFO head
- o_src_stb  out  1  = i_fifo_stb & latched wr, combinational

## Operation
- States: IDLE, CALC, WAIT_DATA, ISSUE, WAIT_FIN, RELEASE, DONE.
- IDLE: o_busy=0. On i_cmd_stb, latch wr, dw_addr=i_cmd_address[31:2], remaining=i_cmd_dword_cnt, requester ID, then o_busy=1. If count==0 → DONE (no TLP); else → CALC.
- CALC: seg_len = min(remaining, max_dw, to_4k).
  - max_dw = 32<<size, using MPS for writes and MRRS for reads.
  - to_4k = 1024 − dw_addr[9:0].
  - seg_len registered (11 bits). → WAIT_DATA if wr, else ISSUE.
- WAIT_DATA: when i_src_count ≥ seg_len, set o_fifo_rdy=1 and → ISSUE.
- o_fifo_rdy clears the cycle after i_fifo_act is seen high; it is never reasserted within a segment.
- ISSUE: o_egress_en=1 → WAIT_FIN.
- WAIT_FIN: on i_egress_finished:
  - o_egress_en=0; dw_addr += seg_len; remaining −= seg_len.
  - Reads only: tag = (tag+1) mod TAG_COUNT.
  - → RELEASE.
- RELEASE: wait for i_egress_finished=0. Then → DONE if remaining==0, else → CALC.
- DONE: o_cmd_done=1 for one cycle, o_busy=0 → IDLE.
- All o_egress_* fields and o_fifo_size hold stable from CALC exit through RELEASE.
- Address wrap past 4 GB is not supported; the 4 KB split guarantees no segment crosses it.

## Timing
- Reset values:
  - o_busy, o_cmd_done, o_egress_en, o_fifo_rdy: 0.
  - Tag counter, o_egress_* registers, o_fifo_size: 0.
- First-segment latency for a read: stb → en = 3 cycles (IDLE, CALC, ISSUE).
- Between segments: finished → next en ≥ 3 cycles (RELEASE, CALC, ISSUE).
- Reset mid-request: immediate abort to IDLE; no o_cmd_done; tag counter resets to 0.
- i_cmd_stb coincident with DONE is ignored.

## Structure
- The shared pcie defines header supplies MWr32/MRd32 type codes, header flag ranges, and max-size encodings.
- A sub-module pcie_seg_len_calc (combinational min-of-three plus size decode) is natural and separately testable.

## Test plan
- Read 4096 B @0x1000, MRRS=512 B: 8 MRd with length 128, addresses 0x1000+n·0x200, tags 0..7, then one o_cmd_done.
- Write 100 dw @0x0FF0, MPS=128 B:
  - segments 4 dw @0x0FF0, 32 @0x1000, 32 @0x1080, 32 @0x1100;
  - o_src_stb count = 100.
- Write 16 dw with i_src_count held at 10, then raised to 16: o_fifo_rdy stays 0 until the count reaches 16; o_egress_en follows 1 cycle later.
- Read 1024 dw @0x0, MRRS=4096 B: single TLP, o_egress_req_dword_cnt=0, o_fifo_size unaffected.
- Count=0: o_cmd_done 2 cycles after stb, no o_egress_en.
- 40 consecutive 1-dw reads: tags wrap 31→0.
- Reset asserted in WAIT_FIN: all outputs reach reset values next cycle, and a fresh request starts at tag 0.

Source files
------------

// File: rtl/pcie_egress_segmenter_pkg.sv
// Shared types, widths and PCIe encodings for the egress DMA segmenter.
package pcie_egress_segmenter_pkg;

   localparam int unsigned ADDR_W    = 32;
   localparam int unsigned DW_ADDR_W = 30;
   localparam int unsigned CNT_W     = 24;
   localparam int unsigned SEG_W     = 11;
   localparam int unsigned LEN_W     = 10;
   localparam int unsigned TAG_W     = 8;
   localparam int unsigned RID_W     = 16;
   localparam int unsigned FLAGS_W   = 14;
   localparam int unsigned SIZE_W    = 3;
   localparam int unsigned CMD_W     = 8;
   localparam int unsigned DATA_W    = 32;
   localparam int unsigned DW_PER_4K = 1024;

   localparam logic [CMD_W-1:0]  CMD_MWR32    = 8'h40;
   localparam logic [CMD_W-1:0]  CMD_MRD32    = 8'h00;
   localparam logic [SIZE_W-1:0] SIZE_MAX_ENC = 3'd5;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CALC,
      ST_WAIT_DATA,
      ST_ISSUE,
      ST_WAIT_FIN,
      ST_RELEASE,
      ST_DONE
   } state_e;

   typedef struct packed {
      logic [CMD_W-1:0]  command;
      logic [ADDR_W-1:0] address;
      logic [RID_W-1:0]  requester_id;
      logic [TAG_W-1:0]  tag;
   } egress_hdr_t;

   // PCIe max-size encoding to dwords; reserved codes saturate at 4096 B.
   function automatic logic [SEG_W-1:0] size_to_dw(input logic [SIZE_W-1:0] enc);
      logic [SIZE_W-1:0] e;
      e = (enc > SIZE_MAX_ENC) ? SIZE_MAX_ENC : enc;
      return SEG_W'(32) << e;
   endfunction

endpackage

// File: rtl/pcie_egress_segmenter_if.sv
// Command, egress-builder and data-FIFO signals of the egress segmenter.
interface pcie_egress_segmenter_if;
   import pcie_egress_segmenter_pkg::*;

   logic                 i_cmd_stb;
   logic                 i_cmd_wr;
   logic [ADDR_W-1:0]    i_cmd_address;
   logic [CNT_W-1:0]     i_cmd_dword_cnt;
   logic [RID_W-1:0]     i_requester_id;
   logic [SIZE_W-1:0]    i_max_payload_size;
   logic [SIZE_W-1:0]    i_max_read_req_size;
   logic                 o_busy;
   logic                 o_cmd_done;
   logic                 o_egress_en;
   logic [CMD_W-1:0]     o_egress_command;
   logic [FLAGS_W-1:0]   o_egress_flags;
   logic [ADDR_W-1:0]    o_egress_address;
   logic [RID_W-1:0]     o_egress_requester_id;
   logic [TAG_W-1:0]     o_egress_tag;
   logic [LEN_W-1:0]     o_egress_req_dword_cnt;
   logic                 i_egress_finished;
   logic                 o_fifo_rdy;
   logic                 i_fifo_act;
   logic [CNT_W-1:0]     o_fifo_size;
   logic [DATA_W-1:0]    o_fifo_data;
   logic                 i_fifo_stb;
   logic [CNT_W-1:0]     i_src_count;
   logic [DATA_W-1:0]    i_src_data;
   logic                 o_src_stb;

   modport master (
      input  i_cmd_stb, i_cmd_wr, i_cmd_address, i_cmd_dword_cnt, i_requester_id,
             i_max_payload_size, i_max_read_req_size, i_egress_finished,
             i_fifo_act, i_fifo_stb, i_src_count, i_src_data,
      output o_busy, o_cmd_done, o_egress_en, o_egress_command, o_egress_flags,
             o_egress_address, o_egress_requester_id, o_egress_tag,
             o_egress_req_dword_cnt, o_fifo_rdy, o_fifo_size, o_fifo_data, o_src_stb
   );

   modport slave (
      output i_cmd_stb, i_cmd_wr, i_cmd_address, i_cmd_dword_cnt, i_requester_id,
             i_max_payload_size, i_max_read_req_size, i_egress_finished,
             i_fifo_act, i_fifo_stb, i_src_count, i_src_data,
      input  o_busy, o_cmd_done, o_egress_en, o_egress_command, o_egress_flags,
             o_egress_address, o_egress_requester_id, o_egress_tag,
             o_egress_req_dword_cnt, o_fifo_rdy, o_fifo_size, o_fifo_data, o_src_stb
   );

endinterface

// File: rtl/pcie_egress_segmenter_seg_len_calc.sv
// Next segment length: min of remaining dwords, max TLP size and distance to the 4 KB boundary.
module pcie_egress_segmenter_seg_len_calc
   import pcie_egress_segmenter_pkg::*;
(
   input  logic [CNT_W-1:0]  remaining,
   input  logic [9:0]        dw_addr_lo,
   input  logic [SIZE_W-1:0] size,
   output logic [SEG_W-1:0]  seg_len_c
);

   logic [SEG_W-1:0] max_dw_c;
   logic [SEG_W-1:0] to_4k_c;
   logic [SEG_W-1:0] lim_c;

   always_comb begin
      max_dw_c  = size_to_dw(size);
      to_4k_c   = SEG_W'(DW_PER_4K) - SEG_W'(dw_addr_lo);
      lim_c     = (max_dw_c < to_4k_c) ? max_dw_c : to_4k_c;
      seg_len_c = (remaining < CNT_W'(lim_c)) ? SEG_W'(remaining) : lim_c;
   end

endmodule

// File: rtl/pcie_egress_segmenter.sv
// Splits a DMA read/write request into PCIe MRd32/MWr32 TLPs bounded by MPS/MRRS and 4 KB,
// sequencing the egress builder handshake one segment at a time.
module pcie_egress_segmenter
   import pcie_egress_segmenter_pkg::*;
#(
   parameter int unsigned TAG_COUNT = 32
)(
   input  logic                    clk,
   input  logic                    rst,
   pcie_egress_segmenter_if.master bus
);

   localparam logic [TAG_W-1:0] TAG_MASK = TAG_W'(TAG_COUNT - 1);

   state_e               state_q, state_d;
   logic                 wr_q, wr_d;
   logic [DW_ADDR_W-1:0] dw_addr_q, dw_addr_d;
   logic [CNT_W-1:0]     remaining_q, remaining_d;
   logic [TAG_W-1:0]     tag_cnt_q, tag_cnt_d;
   logic [SEG_W-1:0]     seg_len_q, seg_len_d;
   logic                 busy_q, busy_d;
   logic                 cmd_done_q, cmd_done_d;
   logic                 en_q, en_d;
   logic                 fifo_rdy_q, fifo_rdy_d;
   egress_hdr_t          hdr_q, hdr_d;
   logic [SIZE_W-1:0]    size_c;
   logic [SEG_W-1:0]     seg_len_c;
   logic                 unused_addr_lsb;

   assign size_c          = wr_q ? bus.i_max_payload_size : bus.i_max_read_req_size;
   assign unused_addr_lsb = ^bus.i_cmd_address[1:0];

   pcie_egress_segmenter_seg_len_calc u_seg_len (
      .remaining  (remaining_q),
      .dw_addr_lo (dw_addr_q[9:0]),
      .size       (size_c),
      .seg_len_c  (seg_len_c)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         wr_q        <= 1'b0;
         dw_addr_q   <= '0;
         remaining_q <= '0;
         tag_cnt_q   <= '0;
         seg_len_q   <= '0;
         busy_q      <= 1'b0;
         cmd_done_q  <= 1'b0;
         en_q        <= 1'b0;
         fifo_rdy_q  <= 1'b0;
         hdr_q       <= '0;
      end else begin
         state_q     <= state_d;
         wr_q        <= wr_d;
         dw_addr_q   <= dw_addr_d;
         remaining_q <= remaining_d;
         tag_cnt_q   <= tag_cnt_d;
         seg_len_q   <= seg_len_d;
         busy_q      <= busy_d;
         cmd_done_q  <= cmd_done_d;
         en_q        <= en_d;
         fifo_rdy_q  <= fifo_rdy_d;
         hdr_q       <= hdr_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      wr_d        = wr_q;
      dw_addr_d   = dw_addr_q;
      remaining_d = remaining_q;
      tag_cnt_d   = tag_cnt_q;
      seg_len_d   = seg_len_q;
      busy_d      = busy_q;
      cmd_done_d  = 1'b0;
      en_d        = en_q;
      fifo_rdy_d  = fifo_rdy_q;
      hdr_d       = hdr_q;

      // Segment data is offered once; the claim retires it.
      if (fifo_rdy_q && bus.i_fifo_act) fifo_rdy_d = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (bus.i_cmd_stb) begin
               wr_d               = bus.i_cmd_wr;
               dw_addr_d          = bus.i_cmd_address[ADDR_W-1:2];
               remaining_d        = bus.i_cmd_dword_cnt;
               hdr_d.requester_id = bus.i_requester_id;
               busy_d             = 1'b1;
               state_d            = (bus.i_cmd_dword_cnt == '0) ? ST_DONE : ST_CALC;
            end
         end
         ST_CALC: begin
            seg_len_d     = seg_len_c;
            hdr_d.command = wr_q ? CMD_MWR32 : CMD_MRD32;
            hdr_d.address = {dw_addr_q, 2'b00};
            hdr_d.tag     = tag_cnt_q;
            state_d       = wr_q ? ST_WAIT_DATA : ST_ISSUE;
         end
         ST_WAIT_DATA: begin
            if (bus.i_src_count >= CNT_W'(seg_len_q)) begin
               fifo_rdy_d = 1'b1;
               state_d    = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            en_d    = 1'b1;
            state_d = ST_WAIT_FIN;
         end
         ST_WAIT_FIN: begin
            if (bus.i_egress_finished) begin
               en_d        = 1'b0;
               dw_addr_d   = dw_addr_q + DW_ADDR_W'(seg_len_q);
               remaining_d = remaining_q - CNT_W'(seg_len_q);
               if (!wr_q) tag_cnt_d = TAG_W'(tag_cnt_q + TAG_W'(1)) & TAG_MASK;
               state_d     = ST_RELEASE;
            end
         end
         ST_RELEASE: begin
            if (!bus.i_egress_finished) state_d = (remaining_q == '0) ? ST_DONE : ST_CALC;
         end
         ST_DONE: begin
            cmd_done_d = 1'b1;
            busy_d     = 1'b0;
            state_d    = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign bus.o_busy                 = busy_q;
   assign bus.o_cmd_done             = cmd_done_q;
   assign bus.o_egress_en            = en_q;
   assign bus.o_egress_command       = hdr_q.command;
   assign bus.o_egress_flags         = '0;
   assign bus.o_egress_address       = hdr_q.address;
   assign bus.o_egress_requester_id  = hdr_q.requester_id;
   assign bus.o_egress_tag           = hdr_q.tag;
   assign bus.o_egress_req_dword_cnt = seg_len_q[LEN_W-1:0];
   assign bus.o_fifo_rdy             = fifo_rdy_q;
   assign bus.o_fifo_size            = CNT_W'(seg_len_q);
   assign bus.o_fifo_data            = bus.i_src_data;
   assign bus.o_src_stb              = bus.i_fifo_stb & wr_q;

endmodule

// File: tb/tb_pcie_egress_segmenter.sv
// Directed bench for pcie_egress_segmenter with a segment scoreboard and an egress/FIFO responder.
module tb_pcie_egress_segmenter;
   import pcie_egress_segmenter_pkg::*;

   localparam int TAGS = 32;

   typedef struct {
      logic [31:0] addr;
      int          len;
      logic [7:0]  tag;
      logic [7:0]  cmd;
   } seg_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   pcie_egress_segmenter_if bus();

   pcie_egress_segmenter #(.TAG_COUNT(TAGS)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   seg_t        exp_q[$];
   int          total = 0;
   int          bad = 0;
   int          tag_model = 0;
   logic [31:0] src_ptr = 32'h1000_0000;
   logic [15:0] rid_model = 16'hBEEF;

   int   src_pops = 0;
   int   en_rises = 0;
   int   done_cnt = 0;
   logic en_prev = 1'b0;

   always @(posedge clk) begin
      if (bus.o_src_stb === 1'b1) src_pops++;
      if (bus.o_cmd_done === 1'b1) done_cnt++;
      if (bus.o_egress_en === 1'b1 && !en_prev) en_rises++;
      en_prev = (bus.o_egress_en === 1'b1);
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Reference split of a request into expected segments.
   task automatic push_model(input logic wr, input logic [31:0] addr, input int cnt, input int size);
      logic [29:0] dw;
      int rem, mx, to4k, len;
      dw  = addr[31:2];
      rem = cnt;
      mx  = 32 << ((size > 5) ? 5 : size);
      while (rem > 0) begin
         to4k = 1024 - int'(dw[9:0]);
         len  = rem;
         if (mx < len) len = mx;
         if (to4k < len) len = to4k;
         exp_q.push_back('{addr: {dw, 2'b00}, len: len, tag: 8'(tag_model),
                           cmd: (wr ? 8'h40 : 8'h00)});
         if (!wr) tag_model = (tag_model + 1) % TAGS;
         dw  = dw + 30'(len);
         rem = rem - len;
      end
   endtask

   task automatic send(input logic wr, input logic [31:0] addr, input int cnt,
                       input int mps, input int mrrs);
      push_model(wr, addr, cnt, wr ? mps : mrrs);
      bus.i_cmd_wr            = wr;
      bus.i_cmd_address       = addr;
      bus.i_cmd_dword_cnt     = 24'(cnt);
      bus.i_max_payload_size  = 3'(mps);
      bus.i_max_read_req_size = 3'(mrrs);
      bus.i_cmd_stb           = 1'b1;
      tick();
      bus.i_cmd_stb           = 1'b0;
   endtask

   task automatic serve(output int lat);
      seg_t e;
      lat = 0;
      while (bus.o_egress_en !== 1'b1 && lat < 64) begin
         tick();
         lat++;
      end
      check("en_rise", 32'(bus.o_egress_en), 1);
      if (bus.o_egress_en !== 1'b1) begin
         exp_q.delete();
         return;
      end
      e = exp_q.pop_front();
      check("seg_addr", bus.o_egress_address, e.addr);
      check("seg_len", 32'(bus.o_egress_req_dword_cnt), 32'(10'(e.len)));
      check("seg_tag", 32'(bus.o_egress_tag), 32'(e.tag));
      check("seg_cmd", 32'(bus.o_egress_command), 32'(e.cmd));
      check("seg_flags", 32'(bus.o_egress_flags), 0);
      check("seg_rid", 32'(bus.o_egress_requester_id), 32'(rid_model));
      if (e.cmd == 8'h40) begin
         check("fifo_rdy", 32'(bus.o_fifo_rdy), 1);
         check("fifo_size", 32'(bus.o_fifo_size), 32'(e.len));
         bus.i_fifo_act = 1'b1;
         tick();
         bus.i_fifo_act = 1'b0;
         check("fifo_rdy_clr", 32'(bus.o_fifo_rdy), 0);
         for (int k = 0; k < e.len; k++) begin
            bus.i_src_data = src_ptr;
            bus.i_fifo_stb = 1'b1;
            #1;
            if (k == 0) begin
               check("fifo_data", bus.o_fifo_data, src_ptr);
               check("src_stb_wr", 32'(bus.o_src_stb), 1);
            end
            tick();
            src_ptr++;
         end
         bus.i_fifo_stb = 1'b0;
      end else begin
         bus.i_fifo_stb = 1'b1;
         #1;
         check("src_stb_rd", 32'(bus.o_src_stb), 0);
         bus.i_fifo_stb = 1'b0;
      end
      tick();
      check("en_hold", 32'(bus.o_egress_en), 1);
      bus.i_egress_finished = 1'b1;
      tick();
      bus.i_egress_finished = 1'b0;
      check("en_drop", 32'(bus.o_egress_en), 0);
   endtask

   task automatic wait_done();
      int n = 0;
      while (bus.o_cmd_done !== 1'b1 && n < 64) begin
         tick();
         n++;
      end
      check("cmd_done", 32'(bus.o_cmd_done), 1);
      check("busy_at_done", 32'(bus.o_busy), 0);
      tick();
      check("done_pulse", 32'(bus.o_cmd_done), 0);
   endtask

   task automatic run(input logic wr, input logic [31:0] addr, input int cnt,
                      input int mps, input int mrrs, output int first_lat);
      int lat, rises0, nseg;
      bit first;
      first     = 1'b1;
      first_lat = -1;
      rises0    = en_rises;
      send(wr, addr, cnt, mps, mrrs);
      nseg = exp_q.size();
      while (exp_q.size() > 0) begin
         serve(lat);
         if (first) first_lat = lat + 1;
         first = 1'b0;
      end
      wait_done();
      check("seg_count", 32'(en_rises - rises0), 32'(nseg));
   endtask

   task automatic check_reset_outputs(input string pfx);
      check({pfx, "_busy"}, 32'(bus.o_busy), 0);
      check({pfx, "_done"}, 32'(bus.o_cmd_done), 0);
      check({pfx, "_en"}, 32'(bus.o_egress_en), 0);
      check({pfx, "_rdy"}, 32'(bus.o_fifo_rdy), 0);
      check({pfx, "_tag"}, 32'(bus.o_egress_tag), 0);
      check({pfx, "_addr"}, bus.o_egress_address, 0);
      check({pfx, "_len"}, 32'(bus.o_egress_req_dword_cnt), 0);
      check({pfx, "_size"}, 32'(bus.o_fifo_size), 0);
      check({pfx, "_rid"}, 32'(bus.o_egress_requester_id), 0);
   endtask

   initial begin
      int lat, base, rises0, done0, n;

      rst                     = 1'b1;
      bus.i_cmd_stb           = 1'b0;
      bus.i_cmd_wr            = 1'b0;
      bus.i_cmd_address       = '0;
      bus.i_cmd_dword_cnt     = '0;
      bus.i_requester_id      = rid_model;
      bus.i_max_payload_size  = '0;
      bus.i_max_read_req_size = '0;
      bus.i_egress_finished   = 1'b0;
      bus.i_fifo_act          = 1'b0;
      bus.i_fifo_stb          = 1'b0;
      bus.i_src_count         = 24'd1000;
      bus.i_src_data          = '0;
      repeat (3) tick();
      check_reset_outputs("rst");
      rst = 1'b0;
      tick();

      // 4 KB read in 512 B requests: 8 TLPs, tags 0..7, 3-cycle first latency.
      run(1'b0, 32'h0000_1000, 1024, 0, 2, lat);
      check("rd_latency", 32'(lat), 3);

      // 100-dword write crossing the 4 KB boundary at MPS 128 B.
      base = src_pops;
      run(1'b1, 32'h0000_0FF0, 100, 0, 0, lat);
      check("src_pops", 32'(src_pops - base), 100);

      // Write gated by source occupancy.
      bus.i_src_count = 24'd10;
      send(1'b1, 32'h0000_2000, 16, 0, 0);
      repeat (5) tick();
      check("gate_rdy_lo", 32'(bus.o_fifo_rdy), 0);
      check("gate_en_lo", 32'(bus.o_egress_en), 0);
      check("gate_busy", 32'(bus.o_busy), 1);
      bus.i_src_count = 24'd16;
      tick();
      check("gate_rdy_hi", 32'(bus.o_fifo_rdy), 1);
      check("gate_en_wait", 32'(bus.o_egress_en), 0);
      tick();
      check("gate_en_hi", 32'(bus.o_egress_en), 1);
      serve(lat);
      wait_done();
      bus.i_src_count = 24'd1000;

      // 1024-dword single read; reserved MRRS code saturates at 4096 B, length encodes as 0.
      run(1'b0, 32'h0000_0000, 1024, 0, 7, lat);

      // Zero-length request, plus a strobe landing in DONE that must be dropped.
      rises0 = en_rises;
      send(1'b0, 32'h0000_0000, 0, 0, 0);
      check("z_done_early", 32'(bus.o_cmd_done), 0);
      check("z_busy", 32'(bus.o_busy), 1);
      bus.i_cmd_dword_cnt = 24'd5;
      bus.i_cmd_stb       = 1'b1;
      tick();
      bus.i_cmd_stb       = 1'b0;
      check("z_done", 32'(bus.o_cmd_done), 1);
      check("z_busy_lo", 32'(bus.o_busy), 0);
      repeat (4) tick();
      check("z_ignored_busy", 32'(bus.o_busy), 0);
      check("z_no_en", 32'(en_rises - rises0), 0);

      // Consecutive 1-dword reads walk the tag counter through its wrap.
      for (int i = 0; i < 40; i++) run(1'b0, 32'h0000_0100 + 32'(4 * i), 1, 0, 0, lat);

      // Reset while a TLP is outstanding.
      send(1'b0, 32'h0000_3000, 64, 0, 0);
      n = 0;
      while (bus.o_egress_en !== 1'b1 && n < 64) begin
         tick();
         n++;
      end
      check("mid_en", 32'(bus.o_egress_en), 1);
      done0 = done_cnt;
      rst   = 1'b1;
      tick();
      check_reset_outputs("mid_rst");
      rst = 1'b0;
      exp_q.delete();
      tag_model = 0;
      repeat (4) tick();
      check("mid_no_done", 32'(done_cnt - done0), 0);
      run(1'b0, 32'h0000_0040, 1, 0, 0, lat);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
